// File: rtl/rsa_operand_fetch.sv
// Operand SRAM read initiator: streams message, key and modulus regions over valid/ready.
// Define RSA_FETCH_REVERSE_EN to read each region high-to-low (MSW first).
module rsa_operand_fetch #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 32,
    parameter int unsigned WORDS    = 64,
    parameter int unsigned MSG_BASE = 0,
    parameter int unsigned KEY_BASE = 64,
    parameter int unsigned MOD_BASE = 128
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          sram_en,
    output logic [AW-1:0] sram_addr,
    input  logic [DW-1:0] sram_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_sel,
    output logic          out_last
);
    localparam int unsigned IW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e          state_q;
    logic [1:0]      sel_q;
    logic [IW-1:0]   idx_q;
    logic [AW-1:0]   addr_q;
    logic            inflight_q;
    logic [1:0]      if_sel_q;
    logic            if_last_q;

    logic [DW-1:0]   data_mem [2];
    logic [1:0]      sel_mem  [2];
    logic            last_mem [2];
    logic            rd_ptr_q;
    logic            wr_ptr_q;
    logic [1:0]      count_q;

    logic            pop;
    logic            idx_last;
    logic [2:0]      occ;

    function automatic logic [AW-1:0] region_base(input logic [1:0] s);
        case (s)
            2'd1:    return AW'(KEY_BASE);
            2'd2:    return AW'(MOD_BASE);
            default: return AW'(MSG_BASE);
        endcase
    endfunction

    function automatic logic [AW-1:0] region_first(input logic [1:0] s);
`ifdef RSA_FETCH_REVERSE_EN
        return region_base(s) + AW'(WORDS - 1);
`else
        return region_base(s);
`endif
    endfunction

    assign out_valid = (count_q != 2'd0);
    assign out_data  = data_mem[rd_ptr_q];
    assign out_sel   = sel_mem[rd_ptr_q];
    assign out_last  = last_mem[rd_ptr_q];
    assign pop       = out_valid & out_ready;
    assign idx_last  = (idx_q == IW'(WORDS - 1));
    assign sram_addr = addr_q;
    assign busy      = (state_q == StFetch) || (state_q == StDrain);
    assign done      = (state_q == StDone);

    // Stored plus in-flight words, less the one leaving this cycle, must leave room.
    assign occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign sram_en = (state_q == StFetch) && (occ < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 2'd0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                        sel_q   <= 2'd0;
                        idx_q   <= '0;
                        addr_q  <= region_first(2'd0);
                    end
                end
                StFetch: begin
                    if (sram_en) begin
                        if (idx_last && sel_q == 2'd2) begin
                            state_q <= StDrain;
                        end else if (idx_last) begin
                            sel_q  <= sel_q + 2'd1;
                            idx_q  <= '0;
                            addr_q <= region_first(sel_q + 2'd1);
                        end else begin
                            idx_q  <= idx_q + IW'(1);
`ifdef RSA_FETCH_REVERSE_EN
                            addr_q <= addr_q - AW'(1);
`else
                            addr_q <= addr_q + AW'(1);
`endif
                        end
                    end
                end
                StDrain: begin
                    if (count_q == 2'd0 && !inflight_q) state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read tag follows the SRAM's one-cycle latency so the capture knows its region.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            if_sel_q   <= 2'd0;
            if_last_q  <= 1'b0;
        end else begin
            inflight_q <= sram_en;
            if_sel_q   <= sel_q;
            if_last_q  <= idx_last;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                data_mem[i] <= '0;
                sel_mem[i]  <= 2'd0;
                last_mem[i] <= 1'b0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (inflight_q) begin
                data_mem[wr_ptr_q] <= sram_data;
                sel_mem[wr_ptr_q]  <= if_sel_q;
                last_mem[wr_ptr_q] <= if_last_q;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            case ({inflight_q, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_rsa_operand_fetch.sv
// Scoreboard bench for rsa_operand_fetch: directed runs, SRAM model, decoupled monitor.
module tb_rsa_operand_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, sram_en, out_valid, out_last;
    logic        out_ready = 1'b1;
    logic [7:0]  sram_addr;
    logic [31:0] sram_data = '0;
    logic [31:0] out_data;
    logic [1:0]  out_sel;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  s;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          words = 0;
    int          en_cnt = 0;
    logic        stall_q = 1'b0;
    logic [31:0] held_d;
    logic [1:0]  held_s;
    logic        held_l;

    rsa_operand_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sram_en   (sram_en),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {~a, 8'h3C, a, a ^ 8'hA5};
    endfunction

    function automatic logic [7:0] exp_addr(input int s, input int i);
`ifdef RSA_FETCH_REVERSE_EN
        return 8'(s * 64 + 63 - i);
`else
        return 8'(s * 64 + i);
`endif
    endfunction

    always @(posedge clk) begin
        if (sram_en) sram_data <= mem_word(sram_addr);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (sram_en) begin
                en_cnt++;
                check("addr_range", {31'd0, sram_addr <= 8'd191}, 32'd1);
            end
            if (stall_q) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", out_data, held_d);
                check("stall_sel", {30'd0, out_sel}, {30'd0, held_s});
                check("stall_last", {31'd0, out_last}, {31'd0, held_l});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_word: got %0h, expected no word", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", out_data, e.d);
                    check("word_sel", {30'd0, out_sel}, {30'd0, e.s});
                    check("word_last", {31'd0, out_last}, {31'd0, e.l});
                end
                words++;
            end
            stall_q = out_valid && !out_ready;
            held_d  = out_data;
            held_s  = out_sel;
            held_l  = out_last;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 64; i++) begin
                exp_t e;
                e.d = mem_word(exp_addr(s, i));
                e.s = 2'(s);
                e.l = (i == 63);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        push_all();
        cycle();
        start = 1'b0;
    endtask

    // Runs until one done pulse or the budget expires; mode 1 toggles out_ready.
    task automatic run(input int mode, input int budget, input int w0, input string tag);
        int d0;
        d0 = done_cnt;
        for (int c = 0; c < budget && done_cnt == d0; c++) begin
            out_ready = (mode == 1) ? c[0] : 1'b1;
            cycle();
        end
        out_ready = 1'b1;
        repeat (4) cycle();
        check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
        check({tag, "_words"}, 32'(words - w0), 32'd192);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_sram_en"}, {31'd0, sram_en}, 32'd0);
        check({tag, "_sram_addr"}, {24'd0, sram_addr}, 32'd0);
        check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_out_data"}, out_data, 32'd0);
        check({tag, "_out_sel"}, {30'd0, out_sel}, 32'd0);
        check({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        int e0;
        int d0;
        repeat (3) cycle();
        rst = 1'b0;
        check_reset_state("reset");

        // Full rate with latency check.
        w0 = words;
        do_start();
        check("lat_busy", {31'd0, busy}, 32'd1);
        check("lat_sram_en", {31'd0, sram_en}, 32'd1);
        check("lat_first_addr", {24'd0, sram_addr}, {24'd0, exp_addr(0, 0)});
        check("lat_valid_c1", {31'd0, out_valid}, 32'd0);
        cycle();
        check("lat_valid_c2", {31'd0, out_valid}, 32'd0);
        cycle();
        check("lat_valid_c3", {31'd0, out_valid}, 32'd1);
        run(0, 400, w0, "full");

        // Ready toggling every cycle.
        w0 = words;
        do_start();
        run(1, 800, w0, "toggle");

        // Stalled sink right after start: only two reads may issue.
        w0 = words;
        out_ready = 1'b0;
        e0 = en_cnt;
        do_start();
        repeat (20) cycle();
        check("stall_reads", 32'(en_cnt - e0), 32'd2);
        check("stall_valid_held", {31'd0, out_valid}, 32'd1);
        run(0, 400, w0, "stall");

        // Reset after word 100, then replay.
        w0 = words;
        d0 = done_cnt;
        do_start();
        for (int c = 0; c < 300 && words - w0 < 100; c++) cycle();
        check("abort_at_100", 32'(words - w0), 32'd100);
        rst = 1'b1;
        cycle();
        check_reset_state("abort");
        rst = 1'b0;
        exp_q.delete();
        repeat (5) cycle();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_no_words", {31'd0, out_valid}, 32'd0);
        w0 = words;
        do_start();
        check("replay_first_addr", {24'd0, sram_addr}, {24'd0, exp_addr(0, 0)});
        run(0, 400, w0, "replay");

        // Start pulsed while busy.
        w0 = words;
        do_start();
        repeat (10) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (60) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        run(0, 400, w0, "restart_ignored");
        repeat (10) cycle();
        check("restart_still_idle", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
